// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the vector-processor instruction front end.
//   IW            : instruction word width (13 bits)
//   *_MSB/*_LSB   : field positions inside an instruction word
//                   [12:11] opcode, [10:9] register select, [8:0] address
//   opcode_e      : instruction classes (load/store/add/mul)
//   state_e       : sequencer FSM state encoding
//   is_arith()    : true for classes that occupy the A-register datapath
// -----------------------------------------------------------------------------
package vec_pkg;

  localparam int IW = 13;

  localparam int OP_MSB   = 12;
  localparam int OP_LSB   = 11;
  localparam int REG_MSB  = 10;
  localparam int REG_LSB  = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_MUL   = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // add/mul work on 512-bit A registers and need a longer issue slot.
  function automatic logic is_arith(input opcode_e op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/vec_prog_ram.sv
// -----------------------------------------------------------------------------
// vec_prog_ram
// DEPTH x IW program buffer: one synchronous write port, one asynchronous
// read port.
//   clk      in   clock
//   we       in   write enable (already qualified by the caller)
//   wr_addr  in   write index
//   wr_data  in   write word
//   rd_addr  in   read index
//   rd_data  out  word at rd_addr (combinational)
// -----------------------------------------------------------------------------
module vec_prog_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
);

  logic [IW-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch on purpose: the program must survive a
  // reset, and a reset-free array maps onto plain register-file/RAM cells.
  // NOTE: non-blocking assignment in clocked logic keeps every reader seeing
  // the pre-edge value, independent of process ordering.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/vec_instr_sequencer.sv
// -----------------------------------------------------------------------------
// vec_instr_sequencer
// Stores a short program of vector instructions and replays it, one word per
// issue slot, onto the processor's instruction input. Load/store words are
// held MEM_CYCLES cycles, add/mul words ARITH_CYCLES cycles.
//   clk          in   clock, all state on rising edge
//   reset        in   synchronous, active-high
//   prog_we      in   write program entry (only honoured in IDLE without start)
//   prog_addr    in   entry index
//   prog_data    in   instruction word
//   start        in   begin replay from entry 0
//   prog_len     in   entries to issue (0..DEPTH, larger saturates), at start
//   abort        in   stop replay (RUN only)
//   instruction  out  word currently driven to the processor
//   issue        out  first cycle of each newly driven word
//   busy         out  high while replaying
//   pc           out  index of the word currently driven
//   done         out  one-cycle pulse at end of replay
//   aborted      out  with done when the replay was cut short by abort
// -----------------------------------------------------------------------------
module vec_instr_sequencer
  import vec_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int IW           = vec_pkg::IW,
  parameter int MEM_CYCLES   = 1,
  parameter int ARITH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          abort,
  output logic [IW-1:0] instruction,
  output logic          issue,
  output logic          busy,
  output logic [AW-1:0] pc,
  output logic          done,
  output logic          aborted
);

  // The hold counter stores (hold - 1), so it only has to reach HOLD_MAX - 1.
  localparam int HOLD_MAX = (ARITH_CYCLES > MEM_CYCLES) ? ARITH_CYCLES : MEM_CYCLES;
  localparam int CW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          issue_q, issue_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic [AW:0]   len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ram_we;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;

  function automatic logic [CW-1:0] hold_m1(input logic [IW-1:0] w);
    return is_arith(opcode_e'(w[OP_MSB:OP_LSB])) ? CW'(ARITH_CYCLES - 1)
                                                 : CW'(MEM_CYCLES - 1);
  endfunction

  // Writes are only safe while nothing is being replayed; a write that
  // collides with start would race the read of entry 0, so it is dropped too.
  assign ram_we  = prog_we && (state_q == IDLE) && !start;

  // Entry 0 is looked up while idle so it can be issued on the start edge;
  // during RUN the next entry is prefetched combinationally.
  assign rd_addr = (state_q == RUN) ? pc_q + AW'(1) : '0;

  vec_prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_prog_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    issue_d   = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
            instr_d = rd_data;
            pc_d    = '0;
            issue_d = 1'b1;
            cnt_d   = hold_m1(rd_data);
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // Abort wins over any counter or pc progress in the same cycle.
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (({1'b0, pc_q} + (AW+1)'(1)) < len_q) begin
          pc_d    = pc_q + AW'(1);
          instr_d = rd_data;
          issue_d = 1'b1;
          cnt_d   = hold_m1(rd_data);
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      issue_q   <= 1'b0;
      busy_q    <= 1'b0;
      pc_q      <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      issue_q   <= issue_d;
      busy_q    <= busy_d;
      pc_q      <= pc_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
    end
  end

  assign instruction = instr_q;
  assign issue       = issue_q;
  assign busy        = busy_q;
  assign pc          = pc_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_vec_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vec_instr_sequencer
// Scoreboard bench: stimulus tasks push the expected issue/done events (cycle,
// word, pc, aborted) into queues; a negedge monitor pops and compares whenever
// the DUT raises issue or done.
// -----------------------------------------------------------------------------
module tb_vec_instr_sequencer;
  import vec_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [12:0]   prog_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic          abort;
  logic [12:0]   instruction;
  logic          issue;
  logic          busy;
  logic [AW-1:0] pc;
  logic          done;
  logic          aborted;

  vec_instr_sequencer #(
    .DEPTH        (DEPTH),
    .AW           (AW),
    .IW           (13),
    .MEM_CYCLES   (1),
    .ARITH_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .prog_len    (prog_len),
    .abort       (abort),
    .instruction (instruction),
    .issue       (issue),
    .busy        (busy),
    .pc          (pc),
    .done        (done),
    .aborted     (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [12:0] instr;
    logic [3:0]  pc;
  } exp_issue_t;

  typedef struct {
    int unsigned cyc;
    logic        ab;
  } exp_done_t;

  exp_issue_t  exp_issue[$];
  exp_done_t   exp_done[$];
  logic [12:0] model_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hold_of(input logic [12:0] w);
    return w[12] ? 2 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [12:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    model_mem[a] = d;
  endtask

  // Starts a replay now and queues the expected events. Only the first
  // max_issue words are expected; done is expected only if all are issued.
  task automatic run(input int len, input int max_issue, output int unsigned dc);
    int          eff;
    int unsigned t;
    exp_issue_t  e;
    exp_done_t   d;
    eff = (len > DEPTH) ? DEPTH : len;
    t   = cyc + 1;
    for (int i = 0; i < eff; i++) begin
      if (i < max_issue) begin
        e.cyc   = t;
        e.instr = model_mem[i];
        e.pc    = 4'(i);
        exp_issue.push_back(e);
      end
      t += hold_of(model_mem[i]);
    end
    if (max_issue >= eff) begin
      d.cyc = t;
      d.ab  = 1'b0;
      exp_done.push_back(d);
    end
    dc       = t;
    start    = 1'b1;
    prog_len = (AW+1)'(len);
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned target);
    int n = 0;
    while (cyc < target && n < 300) begin
      tick();
      n++;
    end
    if (cyc < target) check("wait_timeout", cyc, target);
  endtask

  // Monitor: compares every issue and done the DUT presents.
  exp_issue_t mon_e;
  exp_done_t  mon_d;
  always @(negedge clk) begin
    if (issue) begin
      if (exp_issue.size() == 0) begin
        check("unexpected_issue", 32'(issue), 0);
      end else begin
        mon_e = exp_issue.pop_front();
        check("issue_cycle", cyc, mon_e.cyc);
        check("issue_instr", 32'(instruction), 32'(mon_e.instr));
        check("issue_pc", 32'(pc), 32'(mon_e.pc));
        check("issue_busy", 32'(busy), 1);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 32'(done), 0);
      end else begin
        mon_d = exp_done.pop_front();
        check("done_cycle", cyc, mon_d.cyc);
        check("done_aborted", 32'(aborted), 32'(mon_d.ab));
        check("done_busy", 32'(busy), 0);
      end
    end else if (aborted) begin
      check("aborted_without_done", 32'(done), 1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dc;
    int unsigned k;
    exp_issue_t  e;
    exp_done_t   d;
    logic [12:0] w;

    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; prog_len = '0; abort = 1'b0;
    repeat (2) tick();
    check("rst_instruction", 32'(instruction), 0);
    check("rst_issue", 32'(issue), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_done", 32'(done), 0);
    check("rst_aborted", 32'(aborted), 0);
    reset = 1'b0;
    tick();

    // Load/store stream: four single-cycle words back to back.
    write_word(0, {4'b0110, 9'h03F});
    write_word(1, {4'b0111, 9'h07F});
    write_word(2, {4'b0000, 9'h03F});
    write_word(3, {4'b0001, 9'h07F});
    run(4, 16, dc);
    wait_cyc(dc + 1);

    // Zero length: done next cycle, busy never high.
    run(0, 16, dc);
    check("zero_len_busy", 32'(busy), 0);
    wait_cyc(dc + 1);
    check("zero_len_busy_after", 32'(busy), 0);

    // Abort while pc=1; abort held into DONE and IDLE must be ignored.
    k = cyc;
    e.cyc = k + 1; e.instr = model_mem[0]; e.pc = 4'd0; exp_issue.push_back(e);
    e.cyc = k + 2; e.instr = model_mem[1]; e.pc = 4'd1; exp_issue.push_back(e);
    d.cyc = k + 3; d.ab = 1'b1; exp_done.push_back(d);
    start = 1'b1; prog_len = 5'd4;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    check("abort_hold_instr", 32'(instruction), 32'(model_mem[1]));
    tick();
    check("abort_hold_instr_idle", 32'(instruction), 32'(model_mem[1]));
    check("abort_idle_busy", 32'(busy), 0);
    tick();
    abort = 1'b0;
    tick();

    // Write during RUN is dropped.
    run(4, 16, dc);
    prog_we = 1'b1; prog_addr = '0; prog_data = 13'h1ABC;
    tick();
    prog_we = 1'b0;
    wait_cyc(dc + 1);
    // Write in the same cycle as start is dropped.
    prog_we = 1'b1; prog_addr = '0; prog_data = 13'h0F0F;
    run(1, 16, dc);
    prog_we = 1'b0;
    wait_cyc(dc + 1);
    run(1, 16, dc);
    wait_cyc(dc + 1);

    // Reset while pc=2, then replay the unchanged program.
    run(4, 3, dc);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_instruction", 32'(instruction), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pc", 32'(pc), 0);
    check("midrst_issue", 32'(issue), 0);
    check("midrst_done", 32'(done), 0);
    reset = 1'b0;
    tick();
    run(4, 16, dc);
    wait_cyc(dc + 1);

    // Arithmetic hold: each word held two cycles.
    write_word(0, {2'b10, 11'b0});
    write_word(1, {2'b11, 11'b0});
    run(2, 16, dc);
    tick();
    check("arith_hold_instr", 32'(instruction), 32'h1000);
    check("arith_hold_issue", 32'(issue), 0);
    check("arith_hold_busy", 32'(busy), 1);
    wait_cyc(dc + 1);

    // Full buffer with mixed classes: exact DEPTH and a saturating length.
    for (int i = 0; i < DEPTH; i++) begin
      w = {2'(i % 4), 2'(i / 4), 9'(i * 37 + 5)};
      write_word(i, w);
    end
    run(16, 16, dc);
    wait_cyc(dc + 1);
    run(31, 16, dc);
    wait_cyc(dc + 1);

    repeat (3) tick();
    check("issue_queue_drained", 32'(exp_issue.size()), 0);
    check("done_queue_drained", 32'(exp_done.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
